// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by DIV and issues one-cycle enable ticks, either
// continuously (burst_len = 0) or as a burst of burst_len ticks ending with a done pulse.
// Optional feature macro: TICK_PRESCALER_AUTO_RELOAD_EN -- when defined, a finished burst
// reloads its length and keeps running instead of returning to idle.
module tick_prescaler #(
  parameter int unsigned DIV     = 10,
  parameter int unsigned BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [BURST_W-1:0] burst_len,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] ticks_left
);

  localparam int unsigned      PreW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0]  PreMax = PreW'(DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [PreW-1:0] pre_q;
  logic            pre_wrap;

`ifdef TICK_PRESCALER_AUTO_RELOAD_EN
  // Burst length captured at accept; later burst_len changes must not affect reloads.
  logic [BURST_W-1:0] len_q;
`endif

  // Prescaler reaches its last count; the next edge issues a tick.
  assign pre_wrap = (pre_q == PreMax);

  // Control FSM with registered tick/busy/done/ticks_left; stop outranks a pending tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pre_q      <= '0;
      tick       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ticks_left <= '0;
`ifdef TICK_PRESCALER_AUTO_RELOAD_EN
      len_q      <= '0;
`endif
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          pre_q <= '0;
          if (start && !stop) begin
            state_q    <= StRun;
            busy       <= 1'b1;
            ticks_left <= burst_len;
`ifdef TICK_PRESCALER_AUTO_RELOAD_EN
            len_q      <= burst_len;
`endif
          end
        end
        StRun: begin
          if (stop) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            pre_q      <= '0;
            ticks_left <= '0;
          end else if (pre_wrap) begin
            pre_q <= '0;
            tick  <= 1'b1;
            // A nonzero count means burst mode; continuous mode keeps ticks_left at 0.
            if (ticks_left == BURST_W'(1)) begin
              done <= 1'b1;
`ifdef TICK_PRESCALER_AUTO_RELOAD_EN
              ticks_left <= len_q;
`else
              state_q    <= StIdle;
              busy       <= 1'b0;
              ticks_left <= '0;
`endif
            end else if (ticks_left != '0) begin
              ticks_left <= ticks_left - BURST_W'(1);
            end
          end else begin
            pre_q <= pre_q + PreW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench for tick_prescaler (DIV=4, BURST_W=8). Expected ticks are pushed to a
// scoreboard queue at start accept and popped on the edge where each tick is due.
module tb_tick_prescaler;

  localparam int DIV = 4;
`ifdef TICK_PRESCALER_AUTO_RELOAD_EN
  localparam bit AutoRl = 1'b1;
`else
  localparam bit AutoRl = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] burst_len = '0;
  logic       tick, busy, done;
  logic [7:0] ticks_left;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         edge_n;
    logic       done;
    logic [7:0] left;
  } exp_t;

  exp_t sb[$];

  tick_prescaler #(.DIV(DIV), .BURST_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .burst_len  (burst_len),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .ticks_left (ticks_left)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a start with the given length, then scramble burst_len to show it is ignored.
  task automatic accept(input int len);
    burst_len = 8'(len);
    start     = 1'b1;
    step();
    start     = 1'b0;
    burst_len = 8'($urandom_range(1, 255));
  endtask

  // Expected ticks (edge after accept, done flag, ticks_left after that edge) for nedges edges.
  function automatic void push_expected(input int len, input int nedges);
    exp_t e;
    int   pos;
    sb.delete();
    for (int i = 1; DIV * i <= nedges; i++) begin
      e.edge_n = DIV * i;
      if (len == 0) begin
        e.done = 1'b0;
        e.left = 8'd0;
      end else begin
        if (!AutoRl && i > len) break;
        pos    = ((i - 1) % len) + 1;
        e.done = (pos == len);
        e.left = (pos == len) ? (AutoRl ? 8'(len) : 8'd0) : 8'(len - pos);
      end
      sb.push_back(e);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if ({tick, done, busy, ticks_left} !== 11'd0) begin
        errors++;
        $display("FAIL reset edge %0d: tick/done/busy/left=%b/%b/%b/%0d want all 0",
                 k, tick, done, busy, ticks_left);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if ({tick, done, busy, ticks_left} !== 11'd0) begin
      errors++;
      $display("FAIL reset release: tick/done/busy/left=%b/%b/%b/%0d want all 0",
               tick, done, busy, ticks_left);
    end
  endtask

  task automatic test_burst();
    exp_t e;
    int   cur_left;
    logic t_exp, d_exp, b_exp;
    push_expected(3, 16);
    accept(3);
    checks++;
    if ({tick, done, busy, ticks_left} !== {1'b0, 1'b0, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL burst accept: tick/done/busy/left=%b/%b/%b/%0d want 0/0/1/3",
               tick, done, busy, ticks_left);
    end
    cur_left = 3;
    for (int k = 1; k <= 16; k++) begin
      step();
      t_exp = 1'b0;
      d_exp = 1'b0;
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e        = sb.pop_front();
        t_exp    = 1'b1;
        d_exp    = e.done;
        cur_left = int'(e.left);
      end
      b_exp = !(!AutoRl && k >= DIV * 3);
      checks++;
      if ({tick, done, busy, ticks_left} !== {t_exp, d_exp, b_exp, 8'(cur_left)}) begin
        errors++;
        $display("FAIL burst edge %0d: tick/done/busy/left=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, tick, done, busy, ticks_left, t_exp, d_exp, b_exp, cur_left);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_continuous();
    exp_t e;
    logic t_exp;
    int   nticks = 0;
    push_expected(0, 40);
    accept(0);
    for (int k = 1; k <= 40; k++) begin
      step();
      t_exp = 1'b0;
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e     = sb.pop_front();
        t_exp = 1'b1;
      end
      if (tick === 1'b1) nticks++;
      checks++;
      if ({tick, done, busy, ticks_left} !== {t_exp, 1'b0, 1'b1, 8'd0}) begin
        errors++;
        $display("FAIL continuous edge %0d: tick/done/busy/left=%b/%b/%b/%0d want %b/0/1/0",
                 k, tick, done, busy, ticks_left, t_exp);
      end
    end
    checks++;
    if (nticks != 10) begin
      errors++;
      $display("FAIL continuous count: got %0d ticks want 10", nticks);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL continuous stop: busy=%b want 0", busy);
    end
  endtask

  task automatic test_stop_collision();
    exp_t e;
    int   cur_left;
    logic t_exp;
    push_expected(2, 7);
    accept(2);
    cur_left = 2;
    for (int k = 1; k <= 7; k++) begin
      step();
      t_exp = 1'b0;
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e        = sb.pop_front();
        t_exp    = 1'b1;
        cur_left = int'(e.left);
      end
      checks++;
      if ({tick, done, busy, ticks_left} !== {t_exp, 1'b0, 1'b1, 8'(cur_left)}) begin
        errors++;
        $display("FAIL stop pre-run edge %0d: tick/done/busy/left=%b/%b/%b/%0d want %b/0/1/%0d",
                 k, tick, done, busy, ticks_left, t_exp, cur_left);
      end
    end
    // Edge 8 would carry the final tick and done; stop must suppress both.
    stop = 1'b1;
    step();
    checks++;
    if ({tick, done, busy, ticks_left} !== 11'd0) begin
      errors++;
      $display("FAIL stop collision: tick/done/busy/left=%b/%b/%b/%0d want all 0",
               tick, done, busy, ticks_left);
    end
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if ({tick, done, busy, ticks_left} !== 11'd0) begin
        errors++;
        $display("FAIL start+stop idle edge %0d: tick/done/busy/left=%b/%b/%b/%0d want all 0",
                 k, tick, done, busy, ticks_left);
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    exp_t e;
    int   cur_left;
    logic t_exp;
    push_expected(5, 8);
    accept(5);
    cur_left = 5;
    for (int k = 1; k <= 8; k++) begin
      step();
      t_exp = 1'b0;
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e        = sb.pop_front();
        t_exp    = 1'b1;
        cur_left = int'(e.left);
      end
      checks++;
      if ({tick, done, busy, ticks_left} !== {t_exp, 1'b0, 1'b1, 8'(cur_left)}) begin
        errors++;
        $display("FAIL reset-mid pre edge %0d: tick/done/busy/left=%b/%b/%b/%0d want %b/0/1/%0d",
                 k, tick, done, busy, ticks_left, t_exp, cur_left);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({tick, done, busy, ticks_left} !== 11'd0) begin
        errors++;
        $display("FAIL reset-mid clear %0d: tick/done/busy/left=%b/%b/%b/%0d want all 0",
                 k, tick, done, busy, ticks_left);
      end
      step();
    end
    push_expected(5, 4);
    accept(5);
    cur_left = 5;
    for (int k = 1; k <= 4; k++) begin
      step();
      t_exp = 1'b0;
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e        = sb.pop_front();
        t_exp    = 1'b1;
        cur_left = int'(e.left);
      end
      checks++;
      if ({tick, done, busy, ticks_left} !== {t_exp, 1'b0, 1'b1, 8'(cur_left)}) begin
        errors++;
        $display("FAIL reset-mid restart edge %0d: tick/done/busy/left=%b/%b/%b/%0d want %b/0/1/%0d",
                 k, tick, done, busy, ticks_left, t_exp, cur_left);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

`ifdef TICK_PRESCALER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    exp_t e;
    int   cur_left;
    logic t_exp, d_exp;
    push_expected(2, 24);
    accept(2);
    cur_left = 2;
    for (int k = 1; k <= 24; k++) begin
      step();
      t_exp = 1'b0;
      d_exp = 1'b0;
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e        = sb.pop_front();
        t_exp    = 1'b1;
        d_exp    = e.done;
        cur_left = int'(e.left);
      end
      checks++;
      if ({tick, done, busy, ticks_left} !== {t_exp, d_exp, 1'b1, 8'(cur_left)}) begin
        errors++;
        $display("FAIL auto-reload edge %0d: tick/done/busy/left=%b/%b/%b/%0d want %b/%b/1/%0d",
                 k, tick, done, busy, ticks_left, t_exp, d_exp, cur_left);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({tick, done, busy, ticks_left} !== 11'd0) begin
      errors++;
      $display("FAIL auto-reload stop: tick/done/busy/left=%b/%b/%b/%0d want all 0",
               tick, done, busy, ticks_left);
    end
  endtask
`else
  task automatic test_back_to_back();
    exp_t e;
    int   cur_left;
    logic t_exp, d_exp, b_exp;
    sb.delete();
    e.edge_n = 4; e.done = 1'b1; e.left = 8'd0; sb.push_back(e);
    e.edge_n = 9; e.done = 1'b1; e.left = 8'd0; sb.push_back(e);
    accept(1);
    cur_left = 1;
    for (int k = 1; k <= 12; k++) begin
      step();
      start = 1'b0;
      t_exp = 1'b0;
      d_exp = 1'b0;
      if (k == 5) cur_left = 1;
      if (sb.size() > 0 && sb[0].edge_n == k) begin
        e        = sb.pop_front();
        t_exp    = 1'b1;
        d_exp    = e.done;
        cur_left = int'(e.left);
      end
      b_exp = (k < 4) || (k >= 5 && k < 9);
      checks++;
      if ({tick, done, busy, ticks_left} !== {t_exp, d_exp, b_exp, 8'(cur_left)}) begin
        errors++;
        $display("FAIL back-to-back edge %0d: tick/done/busy/left=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 k, tick, done, busy, ticks_left, t_exp, d_exp, b_exp, cur_left);
      end
      // Restart request during the done cycle, accepted at the edge that ends it.
      if (k == 4) begin
        burst_len = 8'd1;
        start     = 1'b1;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_burst();
    test_continuous();
    test_stop_collision();
    test_reset_mid_burst();
`ifdef TICK_PRESCALER_AUTO_RELOAD_EN
    test_auto_reload();
`else
    test_back_to_back();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
